// File: rtl/sa_controller.sv
// Systolic-array sequencing controller: walks PRELOAD, STREAM and FLUSH per job
// and generates the weight, input and output buffer traffic for each phase.
package sa_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        PRELOAD = 2'b01,
        STREAM  = 2'b10,
        FLUSH   = 2'b11
    } sa_state_e;
endpackage

module sa_controller
    import sa_pkg::*;
#(
    parameter int SA_ROWS    = 4,
    parameter int SA_COLS    = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int M_WIDTH    = 8,
    parameter int OUT_LAT    = SA_ROWS + SA_COLS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] cfg_w_offset,
    input  logic [ADDR_WIDTH-1:0] cfg_i_offset,
    input  logic [ADDR_WIDTH-1:0] cfg_o_offset,
    input  logic [M_WIDTH-1:0]    cfg_m,
    output logic [1:0]            state_o,
    output logic                  busy,
    output logic                  done,
    output logic                  w_rd_en,
    output logic [ADDR_WIDTH-1:0] w_rd_addr,
    output logic                  pe_load_w,
    output logic                  i_rd_en,
    output logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic                  pe_in_valid,
    output logic                  o_wr_en,
    output logic [ADDR_WIDTH-1:0] o_wr_addr
);

    localparam int MMAX = (2 ** M_WIDTH) - 1;
    localparam int CMAX = (SA_ROWS > MMAX) ? SA_ROWS : MMAX;
    localparam int CW   = $clog2(CMAX + 1);

    sa_state_e             state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [CW-1:0]         j_q, j_d;
    logic [ADDR_WIDTH-1:0] w_off_q, w_off_d;
    logic [ADDR_WIDTH-1:0] i_off_q, i_off_d;
    logic [ADDR_WIDTH-1:0] o_off_q, o_off_d;
    logic [M_WIDTH-1:0]    m_q, m_d;
    logic [OUT_LAT-1:0]    sr_q, sr_d;
    logic [OUT_LAT:0]      sr_ext;
    logic                  done_q, done_d;
    logic                  busy_q;
    logic                  w_en_q, w_en_d;
    logic                  i_en_q, i_en_d;
    logic                  ld_q, iv_q;
    logic                  tap_d;
    logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
    logic [ADDR_WIDTH-1:0] i_addr_q, i_addr_d;
    logic [ADDR_WIDTH-1:0] o_addr_q, o_addr_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        j_d     = j_q;
        w_off_d = w_off_q;
        i_off_d = i_off_q;
        o_off_d = o_off_q;
        m_d     = m_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_m != '0) begin
                        state_d = PRELOAD;
                        cnt_d   = '0;
                        j_d     = '0;
                        w_off_d = cfg_w_offset;
                        i_off_d = cfg_i_offset;
                        o_off_d = cfg_o_offset;
                        m_d     = cfg_m;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            PRELOAD: begin
                if (cnt_q == CW'(SA_ROWS - 1)) begin
                    state_d = STREAM;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STREAM: begin
                if (cnt_q == CW'(m_q) - 1'b1) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FLUSH: begin
                if (j_q == CW'(m_q)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Output tap is the input-read enable aged by OUT_LAT cycles.
        sr_ext = {sr_q, i_en_q};
        sr_d   = sr_ext[OUT_LAT-1:0];
        tap_d  = sr_d[OUT_LAT-1];
        if (tap_d) begin
            j_d = j_d + 1'b1;
        end

        w_en_d   = (state_d == PRELOAD);
        i_en_d   = (state_d == STREAM);
        w_addr_d = w_en_d ? w_off_d + ADDR_WIDTH'(cnt_d) : '0;
        i_addr_d = i_en_d ? i_off_d + ADDR_WIDTH'(cnt_d) : '0;
        o_addr_d = tap_d ? o_off_q + ADDR_WIDTH'(j_q) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            j_q      <= '0;
            w_off_q  <= '0;
            i_off_q  <= '0;
            o_off_q  <= '0;
            m_q      <= '0;
            sr_q     <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            w_en_q   <= 1'b0;
            i_en_q   <= 1'b0;
            ld_q     <= 1'b0;
            iv_q     <= 1'b0;
            w_addr_q <= '0;
            i_addr_q <= '0;
            o_addr_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            j_q      <= j_d;
            w_off_q  <= w_off_d;
            i_off_q  <= i_off_d;
            o_off_q  <= o_off_d;
            m_q      <= m_d;
            sr_q     <= sr_d;
            done_q   <= done_d;
            busy_q   <= (state_d != IDLE);
            w_en_q   <= w_en_d;
            i_en_q   <= i_en_d;
            ld_q     <= w_en_q;
            iv_q     <= i_en_q;
            w_addr_q <= w_addr_d;
            i_addr_q <= i_addr_d;
            o_addr_q <= o_addr_d;
        end
    end

    assign state_o     = state_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign w_rd_en     = w_en_q;
    assign w_rd_addr   = w_addr_q;
    assign pe_load_w   = ld_q;
    assign i_rd_en     = i_en_q;
    assign i_rd_addr   = i_addr_q;
    assign pe_in_valid = iv_q;
    assign o_wr_en     = sr_q[OUT_LAT-1];
    assign o_wr_addr   = o_addr_q;

endmodule

// File: tb/tb_sa_controller.sv
// Directed bench for sa_controller: cycle-by-cycle expectations derived from
// the job timeline (P=4, L=8), with reset, wrap, M=0 and M=255 scenarios.
module tb_sa_controller;

    localparam int P = 4;
    localparam int L = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] cfg_w_offset;
    logic [7:0] cfg_i_offset;
    logic [7:0] cfg_o_offset;
    logic [7:0] cfg_m;
    logic [1:0] state_o;
    logic       busy;
    logic       done;
    logic       w_rd_en;
    logic [7:0] w_rd_addr;
    logic       pe_load_w;
    logic       i_rd_en;
    logic [7:0] i_rd_addr;
    logic       pe_in_valid;
    logic       o_wr_en;
    logic [7:0] o_wr_addr;

    int n_tests = 0;
    int n_fail  = 0;
    int n_i, n_o, n_d;

    sa_controller #(
        .SA_ROWS(4), .SA_COLS(4), .ADDR_WIDTH(8), .M_WIDTH(8), .OUT_LAT(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_w_offset(cfg_w_offset), .cfg_i_offset(cfg_i_offset),
        .cfg_o_offset(cfg_o_offset), .cfg_m(cfg_m),
        .state_o(state_o), .busy(busy), .done(done),
        .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .pe_load_w(pe_load_w),
        .i_rd_en(i_rd_en), .i_rd_addr(i_rd_addr), .pe_in_valid(pe_in_valid),
        .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int c,
                       input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, c, obs, exp);
        end
    endtask

    // c = cycle index after the start edge; c=0 means "expect idle".
    task automatic check_cycle(input int c, input logic [7:0] w,
                               input logic [7:0] i, input logic [7:0] o,
                               input int m);
        logic       en;
        logic [7:0] ea;
        int         st;
        en = (c >= 1 && c <= P);
        ea = en ? w + 8'(c - 1) : 8'h00;
        chk("w_rd_en", c, w_rd_en, en);
        chk("w_rd_addr", c, w_rd_addr, ea);
        chk("pe_load_w", c, pe_load_w, c >= 2 && c <= P + 1);
        en = (c >= P + 1 && c <= P + m);
        ea = en ? i + 8'(c - P - 1) : 8'h00;
        chk("i_rd_en", c, i_rd_en, en);
        chk("i_rd_addr", c, i_rd_addr, ea);
        chk("pe_in_valid", c, pe_in_valid, c >= P + 2 && c <= P + m + 1);
        en = (c >= P + 1 + L && c <= P + m + L);
        ea = en ? o + 8'(c - P - 1 - L) : 8'h00;
        chk("o_wr_en", c, o_wr_en, en);
        chk("o_wr_addr", c, o_wr_addr, ea);
        if (c < 1)               st = 0;
        else if (c <= P)         st = 1;
        else if (c <= P + m)     st = 2;
        else if (c <= P + m + L) st = 3;
        else                     st = 0;
        chk("state_o", c, state_o, st);
        chk("busy", c, busy, st != 0);
        chk("done", c, done, c >= 1 && c == P + m + L + 1);
    endtask

    task automatic run_job(input logic [7:0] w, input logic [7:0] i,
                           input logic [7:0] o, input int m,
                           input bit chg, input int s2, input bit chain,
                           input logic [7:0] nw, input logic [7:0] ni,
                           input logic [7:0] no, input logic [7:0] nm);
        int last;
        last = P + m + L + 1;
        n_i = 0;
        n_o = 0;
        n_d = 0;
        for (int c = 1; c <= last; c++) begin
            @(posedge clk);
            #1;
            check_cycle(c, w, i, o, m);
            n_i += int'(i_rd_en);
            n_o += int'(o_wr_en);
            n_d += int'(done);
            start = (c == s2);
            if (chg && c == 2) begin
                cfg_w_offset = 8'hAA;
                cfg_i_offset = 8'h55;
                cfg_o_offset = 8'hCC;
                cfg_m        = 8'd9;
            end
            if (chain && c == last) begin
                cfg_w_offset = nw;
                cfg_i_offset = ni;
                cfg_o_offset = no;
                cfg_m        = nm;
                start        = 1'b1;
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            check_cycle(0, 8'h00, 8'h00, 8'h00, 0);
        end
    endtask

    task automatic set_cfg(input logic [7:0] w, input logic [7:0] i,
                           input logic [7:0] o, input logic [7:0] m);
        cfg_w_offset = w;
        cfg_i_offset = i;
        cfg_o_offset = o;
        cfg_m        = m;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        set_cfg(8'h00, 8'h00, 8'h00, 8'h00);
        #12;
        check_cycle(0, 8'h00, 8'h00, 8'h00, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(2);

        // Basic job with cfg change at 2, stray start at 6, chained wrap job.
        set_cfg(8'h10, 8'h20, 8'h40, 8'd3);
        start = 1'b1;
        run_job(8'h10, 8'h20, 8'h40, 3, 1'b1, 6, 1'b1,
                8'hFD, 8'hFE, 8'hFF, 8'd4);
        run_job(8'hFD, 8'hFE, 8'hFF, 4, 1'b0, 0, 1'b0,
                8'h00, 8'h00, 8'h00, 8'h00);
        idle_cycles(3);

        // M=0 request completes immediately with no traffic.
        set_cfg(8'h10, 8'h20, 8'h40, 8'd0);
        start = 1'b1;
        @(posedge clk);
        #1;
        chk("m0_done", 1, done, 1'b1);
        chk("m0_busy", 1, busy, 1'b0);
        chk("m0_state", 1, state_o, 2'b00);
        chk("m0_w_rd_en", 1, w_rd_en, 1'b0);
        chk("m0_i_rd_en", 1, i_rd_en, 1'b0);
        chk("m0_o_wr_en", 1, o_wr_en, 1'b0);
        start = 1'b0;
        idle_cycles(14);

        // Asynchronous reset mid-STREAM.
        set_cfg(8'h10, 8'h20, 8'h40, 8'd3);
        start = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk);
            #1;
            check_cycle(c, 8'h10, 8'h20, 8'h40, 3);
            start = 1'b0;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_cycle(0, 8'h00, 8'h00, 8'h00, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(20);

        // Maximum streaming dimension.
        set_cfg(8'h00, 8'h80, 8'h10, 8'd255);
        start = 1'b1;
        run_job(8'h00, 8'h80, 8'h10, 255, 1'b0, 0, 1'b0,
                8'h00, 8'h00, 8'h00, 8'h00);
        chk("m255_reads", 0, n_i, 255);
        chk("m255_writes", 0, n_o, 255);
        chk("m255_dones", 0, n_d, 1);
        idle_cycles(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
